put_pow: RTL

- Sequential inverse of the codebase's get_pow log2 block: takes an exponent `pow` and produces the one-hot value `number = 2**pow`.
- Works iteratively: a register is seeded with 1 and shifted left once per cycle until the exponent count is used up.
- Uses valid/ready handshakes on input and output, so it can sit in a stream with get_pow for round-trip checking.

---
 rtl/put_pow_pkg.sv | 15 +
 rtl/put_pow_cnt.sv | 26 ++
 rtl/put_pow.sv | 100 ++++++++++
 3 files changed

// File: rtl/put_pow_pkg.sv
// Shared types and default sizing for the put_pow exponent-to-one-hot expander.
package put_pow_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_POW_W = 3;
   localparam int unsigned CNT_W     = DEF_POW_W;
   localparam int unsigned MAX_POW   = DEF_WIDTH - 1;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

endpackage

// File: rtl/put_pow_cnt.sv
// Loadable down-counter; `last` flags the final shift step (value == 1).
module put_pow_cnt #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] value,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         value <= value - CNT_W'(1);
      end
   end

   assign last = (value == CNT_W'(1));

endmodule

// File: rtl/put_pow.sv
// Iterative 2**pow expander: seeds a one-hot register with 1 and shifts it left
// once per cycle, with valid/ready handshakes on both sides.
module put_pow
   import put_pow_pkg::*;
#(
   parameter int unsigned WIDTH = MAX_POW + 1,
   parameter int unsigned POW_W = CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [POW_W-1:0] pow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] number,
   output logic             err
);

   state_e           state;
   logic [POW_W-1:0] cnt_value;
   logic             cnt_last;
   logic             cnt_load;
   logic             cnt_en;
   logic             accept;
   logic             pow_oor;
   logic             pow_zero;

   assign accept   = in_valid && in_ready;
   assign pow_oor  = 32'(pow) >= WIDTH;
   assign pow_zero = (pow == '0);

   // Only exponents that actually need shifting load the counter.
   assign cnt_load = (state == StIdle) && accept && !pow_oor && !pow_zero;
   assign cnt_en   = (state == StShift) && (cnt_value != '0);

   put_pow_cnt #(
      .CNT_W (POW_W)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (pow),
      .en       (cnt_en),
      .value    (cnt_value),
      .last     (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         number    <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (pow_oor) begin
                     number    <= '0;
                     err       <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= StDone;
                  end else if (pow_zero) begin
                     number    <= WIDTH'(1);
                     err       <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= StDone;
                  end else begin
                     number <= WIDTH'(1);
                     err    <= 1'b0;
                     state  <= StShift;
                  end
               end
            end
            StShift: begin
               // Exponents reaching here are < WIDTH, so the shift never overflows.
               number <= number << 1;
               if (cnt_last) begin
                  out_valid <= 1'b1;
                  state     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
